// File: rtl/gpr_wb_ctrl.sv
// gpr write-back initiator: request queue, pair splitting and busy scoreboard.
// Optional GPR_WB_BYPASS_EN drives an idle write port from wb_* combinationally.
module gpr_wb_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [2:0]  wb_rd,
  input  logic        wb_pair,
  input  logic [15:0] wb_data,
  output logic [7:0]  register_write,
  output logic [7:0]  rd_data,
  output logic        rd_r0_mux,
  output logic        rd_r1_mux,
  output logic [15:0] cr_data,
  output logic [7:0]  busy
);

  typedef enum logic {IDLE, PAIR_HI} state_t;

  typedef struct packed {
    logic [2:0]  rd;
    logic        pair;
    logic [15:0] data;
  } ent_t;

  ent_t           q [FIFO_DEPTH];
  ent_t           inc;
  ent_t           src;
  logic [PTR_W:0] wptr;
  logic [PTR_W:0] rptr;
  logic [PTR_W:0] cnt;
  logic [PTR_W-1:0] off;
  state_t         state;
  state_t         state_nx;
  logic [2:0]     hi_rd;
  logic [7:0]     hi_data;
  logic           byp_q;
  logic [7:0]     we_q;
  logic [7:0]     we_d;
  logic [7:0]     rdd_q;
  logic [7:0]     rdd_d;
  logic           m0_q;
  logic           m0_d;
  logic           m1_q;
  logic           m1_d;
  logic [15:0]    cr_q;
  logic [15:0]    cr_d;
  logic [7:0]     qmask;
  logic [7:0]     hi_mask;
  logic [7:0]     byp_mask;
  logic           empty;
  logic           full;
  logic           acc;
  logic           direct;
  logic           enq;
  logic           deq;
  logic           pop;
  logic           pair_hi;
  logic           byp_hit;
  logic           show_comb;

  function automatic logic [7:0] mask_of(
    input logic [2:0] rd,
    input logic       pair
  );
    if (pair)
      return 8'h03 << {rd[2:1], 1'b0};
    else
      return 8'h01 << rd;
  endfunction

  assign cnt   = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                 (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);

  assign wb_ready = rst && !full;
  assign acc      = wb_valid && wb_ready;
  assign inc      = {wb_rd, wb_pair, wb_data};
  assign src      = empty ? inc : q[rptr[PTR_W-1:0]];

  // An empty idle queue hands the incoming request straight to the port.
  assign direct  = (state == IDLE) && empty;
  assign pop     = (state == IDLE) && (!empty || acc);
  assign enq     = acc && !direct;
  assign deq     = pop && !empty;
  assign pair_hi = src.pair && (src.rd[2:1] != 2'b00);

`ifdef GPR_WB_BYPASS_EN
  assign byp_hit   = direct && acc && (we_q == 8'h00);
  assign show_comb = byp_hit || ((state == PAIR_HI) && byp_q);
`else
  assign byp_hit   = 1'b0;
  assign show_comb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) begin
        q[wptr[PTR_W-1:0]] <= inc;
        wptr <= wptr + 1'b1;
      end
      if (deq)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      hi_rd   <= '0;
      hi_data <= '0;
      byp_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop && pair_hi) begin
        hi_rd   <= {src.rd[2:1], 1'b1};
        hi_data <= src.data[15:8];
        byp_q   <= byp_hit;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pop && pair_hi) state_nx = PAIR_HI;
      PAIR_HI: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    we_d  = 8'h00;
    m0_d  = 1'b0;
    m1_d  = 1'b0;
    rdd_d = rdd_q;
    cr_d  = cr_q;
    unique case (1'b1)
      (state == PAIR_HI): begin
        we_d  = 8'h01 << hi_rd;
        rdd_d = hi_data;
      end
      (pop && !src.pair): begin
        we_d  = 8'h01 << src.rd;
        rdd_d = src.data[7:0];
      end
      (pop && src.pair && !pair_hi): begin
        we_d = 8'h03;
        m0_d = 1'b1;
        m1_d = 1'b1;
        cr_d = src.data;
      end
      (pop && pair_hi): begin
        we_d  = 8'h01 << {src.rd[2:1], 1'b0};
        rdd_d = src.data[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q  <= '0;
      rdd_q <= '0;
      m0_q  <= 1'b0;
      m1_q  <= 1'b0;
      cr_q  <= '0;
    end else begin
      we_q  <= show_comb ? 8'h00 : we_d;
      m0_q  <= show_comb ? 1'b0 : m0_d;
      m1_q  <= show_comb ? 1'b0 : m1_d;
      rdd_q <= rdd_d;
      cr_q  <= cr_d;
    end
  end

  assign register_write = show_comb ? we_d : we_q;
  assign rd_data        = show_comb ? rdd_d : rdd_q;
  assign rd_r0_mux      = show_comb ? m0_d : m0_q;
  assign rd_r1_mux      = show_comb ? m1_d : m1_q;
  assign cr_data        = show_comb ? cr_d : cr_q;

  always_comb begin
    qmask = 8'h00;
    off   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rptr[PTR_W-1:0];
      if ({1'b0, off} < cnt)
        qmask = qmask | mask_of(q[i].rd, q[i].pair);
    end
  end

  assign hi_mask  = (state == PAIR_HI) ? (8'h01 << hi_rd) : 8'h00;
  assign byp_mask = byp_hit ? mask_of(wb_rd, wb_pair) : 8'h00;
  assign busy     = qmask | register_write | hi_mask | byp_mask;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: per-cycle vector table plus a latency sequence.
// The table assumes the registered port; the latency check adapts to the build.
module tb_gpr_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [2:0]  wb_rd = '0;
  logic        wb_pair = 1'b0;
  logic [15:0] wb_data = '0;
  logic [7:0]  register_write;
  logic [7:0]  rd_data;
  logic        rd_r0_mux;
  logic        rd_r1_mux;
  logic [15:0] cr_data;
  logic [7:0]  busy;

  int n_run = 0;
  int n_fail = 0;

  gpr_wb_ctrl #(.FIFO_DEPTH(2), .PTR_W(1)) dut (
    .clk(clk),
    .rst(rst),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_rd(wb_rd),
    .wb_pair(wb_pair),
    .wb_data(wb_data),
    .register_write(register_write),
    .rd_data(rd_data),
    .rd_r0_mux(rd_r0_mux),
    .rd_r1_mux(rd_r1_mux),
    .cr_data(cr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [2:0]  rd;
    logic        p;
    logic [15:0] d;
    logic        rdy;
    logic [7:0]  we;
    logic [7:0]  rdd;
    logic        m;
    logic [15:0] cr;
    logic [7:0]  bz;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rs, input logic v, input logic [2:0] rd,
    input logic p, input logic [15:0] d, input logic rdy,
    input logic [7:0] we, input logic [7:0] rdd, input logic m,
    input logic [15:0] cr, input logic [7:0] bz
  );
    vec_t t;
    t.rst = rs; t.v = v; t.rd = rd; t.p = p; t.d = d;
    t.rdy = rdy; t.we = we; t.rdd = rdd; t.m = m;
    t.cr = cr; t.bz = bz;
    return t;
  endfunction

  task automatic check(input string name, input logic [42:0] act,
                       input logic [42:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [42:0] obs();
    return {wb_ready, register_write, rd_data, rd_r0_mux, rd_r1_mux,
            cr_data, busy};
  endfunction

  initial begin
    // rst rd/p/data rdy we rdd m cr busy
    tbl[0]  = mk(0,0,0,0,16'h0000, 0,8'h00,8'h00,0,16'h0000,8'h00);
    tbl[1]  = mk(1,1,3,0,16'h00A5, 1,8'h00,8'h00,0,16'h0000,8'h00);
    tbl[2]  = mk(1,0,0,0,16'h0000, 1,8'h08,8'hA5,0,16'h0000,8'h08);
    tbl[3]  = mk(1,0,0,0,16'h0000, 1,8'h00,8'hA5,0,16'h0000,8'h00);
    tbl[4]  = mk(1,1,0,1,16'h1234, 1,8'h00,8'hA5,0,16'h0000,8'h00);
    tbl[5]  = mk(1,0,0,0,16'h0000, 1,8'h03,8'hA5,1,16'h1234,8'h03);
    tbl[6]  = mk(1,0,0,0,16'h0000, 1,8'h00,8'hA5,0,16'h1234,8'h00);
    tbl[7]  = mk(1,1,6,1,16'hBEEF, 1,8'h00,8'hA5,0,16'h1234,8'h00);
    tbl[8]  = mk(1,0,0,0,16'h0000, 1,8'h40,8'hEF,0,16'h1234,8'hC0);
    tbl[9]  = mk(1,0,0,0,16'h0000, 1,8'h80,8'hBE,0,16'h1234,8'h80);
    tbl[10] = mk(1,0,0,0,16'h0000, 1,8'h00,8'hBE,0,16'h1234,8'h00);
    tbl[11] = mk(1,1,2,1,16'hC3C2, 1,8'h00,8'hBE,0,16'h1234,8'h00);
    tbl[12] = mk(1,1,4,1,16'h55A4, 1,8'h04,8'hC2,0,16'h1234,8'h0C);
    tbl[13] = mk(1,1,5,0,16'h0011, 1,8'h08,8'hC3,0,16'h1234,8'h38);
    tbl[14] = mk(1,1,5,0,16'h0022, 1,8'h10,8'hA4,0,16'h1234,8'h30);
    tbl[15] = mk(1,0,0,0,16'h0000, 0,8'h20,8'h55,0,16'h1234,8'h20);
    tbl[16] = mk(1,0,0,0,16'h0000, 1,8'h20,8'h11,0,16'h1234,8'h20);
    tbl[17] = mk(1,0,0,0,16'h0000, 1,8'h20,8'h22,0,16'h1234,8'h20);
    tbl[18] = mk(1,0,0,0,16'h0000, 1,8'h00,8'h22,0,16'h1234,8'h00);
    tbl[19] = mk(1,1,4,1,16'h9988, 1,8'h00,8'h22,0,16'h1234,8'h00);
    tbl[20] = mk(0,0,0,0,16'h0000, 0,8'h10,8'h88,0,16'h1234,8'h30);
    tbl[21] = mk(1,0,0,0,16'h0000, 1,8'h00,8'h00,0,16'h0000,8'h00);
    tbl[22] = mk(1,0,0,0,16'h0000, 1,8'h00,8'h00,0,16'h0000,8'h00);

    repeat (2) @(posedge clk);

`ifndef GPR_WB_BYPASS_EN
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst      = tbl[i].rst;
      wb_valid = tbl[i].v;
      wb_rd    = tbl[i].rd;
      wb_pair  = tbl[i].p;
      wb_data  = tbl[i].d;
      #1;
      check($sformatf("vec%0d", i), obs(),
            {tbl[i].rdy, tbl[i].we, tbl[i].rdd, tbl[i].m, tbl[i].m,
             tbl[i].cr, tbl[i].bz});
    end
`endif

    // Idle-block latency for a byte write to r1.
    @(negedge clk);
    rst = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_release", obs(), {1'b1, 8'h00, 8'h00, 1'b0, 1'b0,
                                 16'h0000, 8'h00});
    wb_valid = 1'b1;
    wb_rd    = 3'd1;
    wb_pair  = 1'b0;
    wb_data  = 16'h005A;
    #1;
`ifdef GPR_WB_BYPASS_EN
    check("lat_same", {35'd0, register_write}, {35'd0, 8'h02});
`else
    check("lat_same", {35'd0, register_write}, {35'd0, 8'h00});
`endif
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
`ifdef GPR_WB_BYPASS_EN
    check("lat_next", {27'd0, register_write, busy}, {27'd0, 8'h00, 8'h00});
`else
    check("lat_next", {27'd0, register_write, busy}, {27'd0, 8'h02, 8'h02});
`endif
    check("lat_data", {35'd0, rd_data}, {35'd0, 8'h5A});
    @(negedge clk);
    #1;
    check("lat_idle", {27'd0, register_write, busy}, {27'd0, 8'h00, 8'h00});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
